frame_fifo_write: RTL and testbench
===================================

Name: frame_fifo_write

Overview:
- Frame-capture counterpart of the SDRAM frame reader: drains a pixel FIFO into SDRAM as fixed-size write bursts through the sdram_core write-burst interface.
- Producer issues a frame request with a base address and length; the block streams exactly that many words to consecutive SDRAM addresses, then pulses a finish strobe.
- Sits in the clk_100m (memory) domain, between a dual-clock capture FIFO (read side) and sdram_core.

Parameters:
- MEM_DATA_BITS, 16, SDRAM data word width.
- ADDR_BITS, 24, SDRAM word address width.
- BURST_BITS, 10, width of the burst length field.
- BURST_SIZE, 128, maximum words per burst; must be ≤ FIFO_DEPTH.
- FIFO_DEPTH, 512, capture FIFO depth; sets the count width (log2(FIFO_DEPTH)+1 bits).

Ports:
- clk  in  1  memory clock (clk_100m).
- rst_n  in  1  asynchronous active-low reset.
- write_req  in  1  frame request; level, held by producer until write_req_ack.
- write_req_ack  out  1  request accepted; high while in ACK state.
- write_finish  out  1  one-cycle pulse when the whole frame has been written.
- write_addr  in  ADDR_BITS  frame base address; sampled on IDLE→ACK.
- write_len  in  ADDR_BITS  frame length in words; sampled on IDLE→ACK.
- fifo_aclr  out  1  capture-FIFO clear; high while in ACK state.
- fifo_rd_data_count  in  log2(FIFO_DEPTH)+1  words available in the FIFO.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_dout  in  MEM_DATA_BITS  FIFO read data.
- wr_burst_req  out  1  burst request to sdram_core.
- wr_burst_len  out  BURST_BITS  words in the current burst.
- wr_burst_addr  out  ADDR_BITS  start address of the current burst.
- wr_burst_data  out  MEM_DATA_BITS  write data; combinationally equal to fifo_dout.
- wr_burst_data_req  in  1  sdram_core requests the next word.
- wr_burst_finish  in  1  sdram_core burst-complete pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async, rst_n=0): state IDLE; all outputs 0; internal address and remaining count 0.
- States: IDLE, ACK, CHECK, BURST, END.
- IDLE:
  - On write_req=1, go to ACK.
  - On the same edge, latch cur_addr←write_addr and remaining←write_len.
- ACK:
  - write_req_ack=1 and fifo_aclr=1.
  - Stay while write_req=1; on write_req=0 go to CHECK.
- CHECK:
  - burst_len = min(BURST_SIZE, remaining).
  - If remaining=0, go to END.
  - Otherwise, if fifo_rd_data_count ≥ burst_len, go to BURST: register wr_burst_len←burst_len and wr_burst_addr←cur_addr, and set wr_burst_req=1.
  - Otherwise wait in CHECK. A short final burst waits for only the remaining words, never a full BURST_SIZE.
- BURST:
  - fifo_rd_en = wr_burst_data_req (combinational, gated by state==BURST).
  - wr_burst_req is held until wr_burst_finish, then cleared on that edge.
  - On wr_burst_finish: cur_addr += wr_burst_len, remaining -= wr_burst_len, go to CHECK.
  - Address arithmetic is ADDR_BITS wide, unsigned, and wraps modulo 2^ADDR_BITS.
- END: write_finish=1 for exactly one cycle, then IDLE.
- Zero-length frame: ACK, then CHECK, then END. One write_finish pulse, no burst is issued.
- write_req seen outside IDLE is ignored; a new frame starts only after returning to IDLE.
- wr_burst_data_req outside BURST: fifo_rd_en stays 0.
- FIFO underflow (data_req with empty FIFO) cannot occur, because the count is checked before each burst.
- Reset mid-burst: immediate return to IDLE with wr_burst_req=0. sdram_core shares the same reset.
- Latency: write_req low (in ACK) to wr_burst_req high is 2 cycles, provided the FIFO already holds burst_len words.

Optional Feature:
- Macro: FRAME_WRITE_TIMEOUT_EN.
- When defined:
  - A 12-bit watchdog counts cycles in BURST and clears on entry to BURST.
  - If 4095 cycles elapse without wr_burst_finish, wr_burst_req is dropped, state goes to IDLE, and extra output write_timeout pulses high for one cycle.
  - write_finish is not pulsed on timeout.
- When undefined: no counter, no write_timeout port; BURST waits indefinitely.

Test Plan:
- Reset: hold rst_n=0 then release → all outputs 0, busy=0, state IDLE.
- write_addr=0x001000, write_len=300, FIFO count 512, core model finishing each burst → three bursts:
  - len 128 @0x001000,
  - len 128 @0x001080,
  - len 44 @0x001100,
  - then one write_finish pulse; fifo_rd_en high exactly 300 cycles in total.
- write_len=0 → write_req_ack high during request, fifo_aclr high during ACK, one write_finish pulse, wr_burst_req never asserted.
- FIFO count held at 100 with write_len=128 → block stays in CHECK with wr_burst_req=0; raise count to 128 → wr_burst_req next cycle with len 128.
- write_addr=0xFFFFC0, write_len=128 → single burst @0xFFFFC0; internal cur_addr wraps to 0x000040 after finish.
- rst_n pulsed low during the 2nd burst of a 300-word frame → wr_burst_req and busy drop immediately; a new write_req afterwards runs normally from its own write_addr.

Source files
------------

// File: rtl/frame_fifo_write.sv
// Drains a capture FIFO into SDRAM as consecutive write bursts of up to BURST_SIZE words per frame.
// Optional watchdog on stalled bursts: define FRAME_WRITE_TIMEOUT_EN.
`timescale 1ns/1ps
module frame_fifo_write #(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BURST_BITS    = 10,
  parameter int BURST_SIZE    = 128,
  parameter int FIFO_DEPTH    = 512
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         write_req,
  output logic                         write_req_ack,
  output logic                         write_finish,
  input  logic [ADDR_BITS-1:0]         write_addr,
  input  logic [ADDR_BITS-1:0]         write_len,
  output logic                         fifo_aclr,
  input  logic [$clog2(FIFO_DEPTH):0]  fifo_rd_data_count,
  output logic                         fifo_rd_en,
  input  logic [MEM_DATA_BITS-1:0]     fifo_dout,
  output logic                         wr_burst_req,
  output logic [BURST_BITS-1:0]        wr_burst_len,
  output logic [ADDR_BITS-1:0]         wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0]     wr_burst_data,
  input  logic                         wr_burst_data_req,
  input  logic                         wr_burst_finish,
`ifdef FRAME_WRITE_TIMEOUT_EN
  output logic                         write_timeout,
`endif
  output logic                         busy
);

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_CHECK, S_BURST, S_END} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [ADDR_BITS-1:0] remaining;
  logic [BURST_BITS-1:0] burst_len;
  logic                 fifo_ready;
`ifdef FRAME_WRITE_TIMEOUT_EN
  logic [11:0]          wdog;
`endif

  // Final burst only needs the remaining words, so the FIFO check uses the clipped length.
  always_comb begin
    burst_len = BURST_BITS'(BURST_SIZE);
    if (remaining < ADDR_BITS'(BURST_SIZE))
      burst_len = BURST_BITS'(remaining);
    fifo_ready = ADDR_BITS'(fifo_rd_data_count) >= ADDR_BITS'(burst_len);
  end

  assign fifo_rd_en    = (state == S_BURST) && wr_burst_data_req;
  assign wr_burst_data = fifo_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      write_req_ack <= 1'b0;
      fifo_aclr     <= 1'b0;
      write_finish  <= 1'b0;
      wr_burst_req  <= 1'b0;
      wr_burst_len  <= '0;
      wr_burst_addr <= '0;
      busy          <= 1'b0;
`ifdef FRAME_WRITE_TIMEOUT_EN
      wdog          <= '0;
      write_timeout <= 1'b0;
`endif
    end else begin
`ifdef FRAME_WRITE_TIMEOUT_EN
      write_timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (write_req) begin
            state         <= S_ACK;
            cur_addr      <= write_addr;
            remaining     <= write_len;
            write_req_ack <= 1'b1;
            fifo_aclr     <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_ACK: begin
          if (!write_req) begin
            state         <= S_CHECK;
            write_req_ack <= 1'b0;
            fifo_aclr     <= 1'b0;
          end
        end
        S_CHECK: begin
          if (remaining == '0) begin
            state        <= S_END;
            write_finish <= 1'b1;
          end else if (fifo_ready) begin
            state         <= S_BURST;
            wr_burst_req  <= 1'b1;
            wr_burst_len  <= burst_len;
            wr_burst_addr <= cur_addr;
`ifdef FRAME_WRITE_TIMEOUT_EN
            wdog          <= '0;
`endif
          end
        end
        S_BURST: begin
          if (wr_burst_finish) begin
            state        <= S_CHECK;
            wr_burst_req <= 1'b0;
            cur_addr     <= cur_addr + ADDR_BITS'(wr_burst_len);
            remaining    <= remaining - ADDR_BITS'(wr_burst_len);
          end
`ifdef FRAME_WRITE_TIMEOUT_EN
          else if (wdog == 12'd4094) begin
            state         <= S_IDLE;
            wr_burst_req  <= 1'b0;
            busy          <= 1'b0;
            write_timeout <= 1'b1;
          end else begin
            wdog <= wdog + 12'd1;
          end
`endif
        end
        S_END: begin
          state        <= S_IDLE;
          write_finish <= 1'b0;
          busy         <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fifo_write.sv
// Randomized self-checking bench for frame_fifo_write against a burst-list reference model.
`timescale 1ns/1ps
module tb_frame_fifo_write;
  localparam int MDB = 16;
  localparam int AB  = 24;
  localparam int BB  = 10;
  localparam int BS  = 128;
  localparam int FD  = 512;

  logic clk = 1'b0;
  logic rst_n;
  logic write_req, write_req_ack, write_finish, fifo_aclr, fifo_rd_en;
  logic [AB-1:0] write_addr, write_len, wr_burst_addr;
  logic [$clog2(FD):0] fifo_rd_data_count;
  logic [MDB-1:0] fifo_dout, wr_burst_data;
  logic wr_burst_req, wr_burst_data_req, wr_burst_finish, busy;
  logic [BB-1:0] wr_burst_len;
`ifdef FRAME_WRITE_TIMEOUT_EN
  logic write_timeout;
`endif

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;

  logic [AB-1:0] exp_addr[$];
  int unsigned   exp_len[$];

  frame_fifo_write #(.MEM_DATA_BITS(MDB), .ADDR_BITS(AB), .BURST_BITS(BB),
                     .BURST_SIZE(BS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .write_req(write_req), .write_req_ack(write_req_ack),
    .write_finish(write_finish), .write_addr(write_addr), .write_len(write_len),
    .fifo_aclr(fifo_aclr), .fifo_rd_data_count(fifo_rd_data_count), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
    .wr_burst_addr(wr_burst_addr), .wr_burst_data(wr_burst_data),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
`ifdef FRAME_WRITE_TIMEOUT_EN
    .write_timeout(write_timeout),
`endif
    .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) if (fifo_rd_en) rd_cnt++;

  // Expected burst list: chop the frame into BS-word pieces at consecutive wrapping addresses.
  task automatic model(input logic [AB-1:0] a, input int unsigned len);
    int unsigned rem = len;
    int unsigned l;
    exp_addr.delete();
    exp_len.delete();
    while (rem > 0) begin
      l = (rem > BS) ? BS : rem;
      exp_addr.push_back(a);
      exp_len.push_back(l);
      a = a + AB'(l);
      rem -= l;
    end
  endtask

  task automatic start_req(input logic [AB-1:0] a, input logic [AB-1:0] len);
    write_addr = a; write_len = len; write_req = 1'b1;
    @(negedge clk);
    checks++;
    if (write_req_ack !== 1'b1 || fifo_aclr !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ack_state ack=%b aclr=%b busy=%b exp=1/1/1", write_req_ack, fifo_aclr, busy);
    end
    write_req = 1'b0;
    write_addr = AB'($urandom); write_len = AB'($urandom);
    @(negedge clk);
    checks++;
    if (write_req_ack !== 1'b0 || fifo_aclr !== 1'b0) begin
      failures++;
      $display("FAIL ack_release ack=%b aclr=%b exp=0/0", write_req_ack, fifo_aclr);
    end
  endtask

  task automatic wait_req(output int waited);
    waited = 0;
    while (wr_burst_req !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (wr_burst_req !== 1'b1) begin
      failures++;
      $display("FAIL burst_req_timeout got=%b exp=1", wr_burst_req);
    end
  endtask

  task automatic serve_burst(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      fifo_dout = MDB'($urandom);
      wr_burst_data_req = 1'b1;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b1 || wr_burst_data !== fifo_dout) begin
        failures++;
        $display("FAIL data_path rd_en=%b data=%h exp=1/%h", fifo_rd_en, wr_burst_data, fifo_dout);
      end
      @(negedge clk);
    end
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b1;
    @(negedge clk);
    wr_burst_finish = 1'b0;
    checks++;
    if (wr_burst_req !== 1'b0) begin
      failures++;
      $display("FAIL req_clear got=%b exp=0", wr_burst_req);
    end
  endtask

  task automatic check_finish(input int unsigned expect_rd, input int r0);
    @(negedge clk);
    checks++;
    if (write_finish !== 1'b1 || wr_burst_req !== 1'b0) begin
      failures++;
      $display("FAIL finish_pulse finish=%b req=%b exp=1/0", write_finish, wr_burst_req);
    end
    @(negedge clk);
    checks++;
    if (write_finish !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL finish_end finish=%b busy=%b exp=0/0", write_finish, busy);
    end
    checks++;
    if (rd_cnt - r0 != int'(expect_rd)) begin
      failures++;
      $display("FAIL rd_en_total got=%0d exp=%0d", rd_cnt - r0, expect_rd);
    end
  endtask

  task automatic run_frame(input logic [AB-1:0] a, input int unsigned len);
    int waited;
    int r0 = rd_cnt;
    model(a, len);
    start_req(a, AB'(len));
    foreach (exp_addr[k]) begin
      wait_req(waited);
      if (k == 0) begin
        checks++;
        if (waited != 1) begin
          failures++;
          $display("FAIL first_latency got=%0d exp=1", waited);
        end
      end
      checks++;
      if (wr_burst_addr !== exp_addr[k] || wr_burst_len !== BB'(exp_len[k])) begin
        failures++;
        $display("FAIL burst%0d addr=%h len=%0d exp=%h/%0d", k, wr_burst_addr, wr_burst_len,
                 exp_addr[k], exp_len[k]);
      end
      serve_burst(exp_len[k]);
    end
    check_finish(len, r0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    write_req = 1'b0; write_addr = '0; write_len = '0; fifo_dout = '0;
    fifo_rd_data_count = 10'd512; wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({write_req_ack, write_finish, fifo_aclr, fifo_rd_en, wr_burst_req, busy} !== 6'b0 ||
        wr_burst_len !== '0 || wr_burst_addr !== '0) begin
      failures++;
      $display("FAIL reset_outputs flags=%b len=%0d addr=%h exp=0", {write_req_ack, write_finish,
               fifo_aclr, fifo_rd_en, wr_burst_req, busy}, wr_burst_len, wr_burst_addr);
    end
    wr_burst_data_req = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL rd_en_idle got=%b exp=0", fifo_rd_en);
    end
    wr_burst_data_req = 1'b0;
  endtask

  task automatic test_frame_300();
    run_frame(24'h001000, 300);
  endtask

  task automatic test_zero_len();
    run_frame(24'h00ABCD, 0);
  endtask

  task automatic test_fifo_hold();
    int r0 = rd_cnt;
    fifo_rd_data_count = 10'd100;
    start_req(24'h020000, 24'd128);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (wr_burst_req !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_wait req=%b busy=%b exp=0/1", wr_burst_req, busy);
      end
    end
    fifo_rd_data_count = 10'd128;
    @(negedge clk);
    checks++;
    if (wr_burst_req !== 1'b1 || wr_burst_len !== 10'd128 || wr_burst_addr !== 24'h020000) begin
      failures++;
      $display("FAIL hold_release req=%b len=%0d addr=%h exp=1/128/020000",
               wr_burst_req, wr_burst_len, wr_burst_addr);
    end
    serve_burst(128);
    check_finish(128, r0);
    fifo_rd_data_count = 10'd512;
  endtask

  task automatic test_addr_wrap();
    logic [AB-1:0] a = 24'hFFFFC0;
    logic [AB-1:0] exp_end = a + 24'd128;
    run_frame(a, 128);
    checks++;
    if (dut.cur_addr !== exp_end) begin
      failures++;
      $display("FAIL addr_wrap got=%h exp=%h", dut.cur_addr, exp_end);
    end
  endtask

  task automatic test_reset_mid_burst();
    int waited;
    start_req(24'h003000, 24'd300);
    wait_req(waited);
    serve_burst(128);
    wait_req(waited);
    checks++;
    if (wr_burst_addr !== 24'h003080) begin
      failures++;
      $display("FAIL mid_second_addr got=%h exp=003080", wr_burst_addr);
    end
    for (int i = 0; i < 10; i++) begin
      wr_burst_data_req = 1'b1;
      @(negedge clk);
    end
    wr_burst_data_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_burst_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset req=%b busy=%b exp=0/0", wr_burst_req, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(24'h00ABC0, 200);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 4; i++)
      run_frame(AB'($urandom), $urandom_range(1, 600));
  endtask

  initial begin
    test_reset();
    test_frame_300();
    test_zero_len();
    test_fifo_hold();
    test_addr_wrap();
    test_reset_mid_burst();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
